// File: rtl/fb_scanout_reader.sv
// Front-bank tile fetch for VGA scanout: maps the timing counters to a tile address,
// reads RGB332 from RAM, and swaps front/back banks at the vertical-blank start.
module fb_scanout_reader #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int TILE_SHIFT = 3,
  parameter int FB_W       = 80,
  parameter int FB_H       = 60,
  parameter int ADDR_W     = 13,
  parameter int RD_LAT     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        hc_in,
  input  logic [9:0]        vc_in,
  input  logic              frame_done,
  output logic              swap_ack,
  output logic              rd_bank,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic [2:0]        pix_red,
  output logic [2:0]        pix_green,
  output logic [1:0]        pix_blue,
  output logic              pix_valid,
  output logic              overrun,
  output logic [7:0]        frame_cnt,
  output logic              dbg_state
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_PEND = 1'b1;

  localparam logic [9:0] H_ACT10 = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT10 = 10'(V_ACTIVE);
  localparam logic [9:0] FB_W10  = 10'(FB_W);
  localparam logic [9:0] FB_H10  = 10'(FB_H);

  // Address generation
  logic [9:0]        w_row;
  logic [9:0]        w_col;
  logic [ADDR_W-1:0] w_row_a;
  logic [ADDR_W-1:0] w_col_a;
  logic [ADDR_W-1:0] w_row_mul;
  logic [ADDR_W-1:0] w_tile;
  logic              w_active;
  logic              w_vbl_start;

  assign w_row   = vc_in >> TILE_SHIFT;
  assign w_col   = hc_in >> TILE_SHIFT;
  assign w_row_a = ADDR_W'(w_row);
  assign w_col_a = ADDR_W'(w_col);

  // 80 = 64 + 16, so the default geometry needs no multiplier.
  generate
    if (FB_W == 80) begin : g_shift_add
      assign w_row_mul = (w_row_a << 6) + (w_row_a << 4);
    end else begin : g_mul
      assign w_row_mul = w_row_a * ADDR_W'(FB_W);
    end
  endgenerate

  assign w_tile   = w_row_mul + w_col_a;
  assign w_active = (hc_in < H_ACT10) && (vc_in < V_ACT10) &&
                    (w_row < FB_H10) && (w_col < FB_W10);
  assign w_vbl_start = (hc_in == 10'd0) && (vc_in == V_ACT10);

  // Pipeline registers
  logic              r_rd_en;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [RD_LAT-1:0] r_vld_sr;
  logic              r_vld_b;
  logic [7:0]        r_data_b;
  logic [2:0]        r_pix_red;
  logic [2:0]        r_pix_green;
  logic [1:0]        r_pix_blue;
  logic              r_pix_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_vld_sr    <= '0;
      r_vld_b     <= 1'b0;
      r_data_b    <= 8'd0;
      r_pix_red   <= 3'd0;
      r_pix_green <= 3'd0;
      r_pix_blue  <= 2'd0;
      r_pix_valid <= 1'b0;
    end else begin
      r_rd_en <= w_active;
      if (w_active) begin
        r_rd_addr <= w_tile;
      end
      // rd_data for a read issued after edge t is valid after edge t+RD_LAT.
      r_vld_sr[0] <= r_rd_en;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld_sr[i] <= r_vld_sr[i-1];
      end
      r_vld_b  <= r_vld_sr[RD_LAT-1];
      r_data_b <= rd_data;
      r_pix_valid <= r_vld_b;
      if (r_vld_b) begin
        r_pix_red   <= r_data_b[7:5];
        r_pix_green <= r_data_b[4:2];
        r_pix_blue  <= r_data_b[1:0];
      end else begin
        r_pix_red   <= 3'd0;
        r_pix_green <= 3'd0;
        r_pix_blue  <= 2'd0;
      end
    end
  end

  // Bank-swap control
  logic       r_state;
  logic       r_rd_bank;
  logic       r_swap_ack;
  logic       r_overrun;
  logic [7:0] r_frame_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_rd_bank   <= 1'b0;
      r_swap_ack  <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_cnt <= 8'd0;
    end else begin
      r_swap_ack <= 1'b0;
      if (w_vbl_start) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
      case (r_state)
        ST_IDLE: begin
          if (frame_done) begin
            r_state <= ST_PEND;
          end
        end
        ST_PEND: begin
          if (w_vbl_start) begin
            // A frame_done landing on the swap cycle belongs to the next frame.
            r_rd_bank  <= ~r_rd_bank;
            r_swap_ack <= 1'b1;
            r_state    <= frame_done ? ST_PEND : ST_IDLE;
          end else if (frame_done) begin
            r_overrun <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign swap_ack  = r_swap_ack;
  assign rd_bank   = r_rd_bank;
  assign rd_en     = r_rd_en;
  assign rd_addr   = r_rd_addr;
  assign pix_red   = r_pix_red;
  assign pix_green = r_pix_green;
  assign pix_blue  = r_pix_blue;
  assign pix_valid = r_pix_valid;
  assign overrun   = r_overrun;
  assign frame_cnt = r_frame_cnt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_fb_scanout_reader.sv
// Bench for fb_scanout_reader: random counter/frame_done stimulus against a
// frame-level model of tile lookup, bank ownership and frame counting.
module tb_fb_scanout_reader;

  localparam int N_TILES = 4800;

  logic        clk;
  logic        rst;
  logic [9:0]  hc_in;
  logic [9:0]  vc_in;
  logic        frame_done;
  logic        swap_ack;
  logic        rd_bank;
  logic        rd_en;
  logic [12:0] rd_addr;
  logic [7:0]  rd_data;
  logic [2:0]  pix_red;
  logic [2:0]  pix_green;
  logic [1:0]  pix_blue;
  logic        pix_valid;
  logic        overrun;
  logic [7:0]  frame_cnt;
  logic        dbg_state;

  fb_scanout_reader dut (
    .clk        (clk),
    .rst        (rst),
    .hc_in      (hc_in),
    .vc_in      (vc_in),
    .frame_done (frame_done),
    .swap_ack   (swap_ack),
    .rd_bank    (rd_bank),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .pix_red    (pix_red),
    .pix_green  (pix_green),
    .pix_blue   (pix_blue),
    .pix_valid  (pix_valid),
    .overrun    (overrun),
    .frame_cnt  (frame_cnt),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  // Two-bank frame RAM with one cycle read latency.
  logic [7:0] mem [2][N_TILES];

  always @(posedge clk) begin
    if (rd_en) begin
      if (int'(rd_addr) < N_TILES) rd_data <= mem[rd_bank][rd_addr];
      else                         rd_data <= 8'h00;
    end
  end

  // scoreboard
  int n_vec;
  int n_err;
  logic [8:0] exp_q[$];

  logic       m_bank;
  logic       m_pend;
  logic       m_ovr;
  logic       m_ack;
  logic [7:0] m_fcnt;
  int         m_addr;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_bank = 1'b0;
    m_pend = 1'b0;
    m_ovr  = 1'b0;
    m_ack  = 1'b0;
    m_fcnt = 8'd0;
    m_addr = 0;
    exp_q.delete();
    repeat (3) exp_q.push_back(9'd0);
  endtask

  function automatic logic [63:0] all_outputs();
    return {30'd0, swap_ack, rd_bank, rd_en, rd_addr, pix_red, pix_green, pix_blue,
            pix_valid, overrun, frame_cnt};
  endfunction

  // Drives one counter position (entered and left on a falling edge) and checks
  // everything the model predicts after the rising edge that samples it.
  task automatic step(input int hc, input int vc, input bit fd);
    logic [8:0] e;
    logic [8:0] pix;
    hc_in      = hc[9:0];
    vc_in      = vc[9:0];
    frame_done = fd;
    m_ack = 1'b0;
    if (hc == 0 && vc == 480) begin
      m_fcnt = m_fcnt + 8'd1;
      if (m_pend) begin
        m_bank = ~m_bank;
        m_ack  = 1'b1;
      end
      m_pend = fd;
    end else if (fd) begin
      if (m_pend) m_ovr = 1'b1;
      m_pend = 1'b1;
    end
    if (hc < 640 && vc < 480) begin
      m_addr = (vc / 8) * 80 + (hc / 8);
      pix = {1'b1, mem[m_bank][m_addr]};
    end else begin
      pix = 9'd0;
    end
    exp_q.push_back(pix);
    @(negedge clk);
    e = exp_q.pop_front();
    check_eq("rd_en",     rd_en, (hc < 640 && vc < 480));
    check_eq("rd_addr",   rd_addr, m_addr);
    check_eq("pix_valid", pix_valid, e[8]);
    check_eq("pix_rgb",   {pix_red, pix_green, pix_blue}, e[7:0]);
    check_eq("swap_ack",  swap_ack, m_ack);
    check_eq("rd_bank",   rd_bank, m_bank);
    check_eq("overrun",   overrun, m_ovr);
    check_eq("frame_cnt", frame_cnt, m_fcnt);
    check_eq("pending",   dbg_state, m_pend);
  endtask

  // Asserts reset dly time units after a falling edge, holds it two cycles
  // with counters and frame_done toggling, and releases on a falling edge.
  task automatic do_reset(input int dly);
    #(dly);
    rst = 1'b0;
    #1;
    check_eq("reset_outputs", all_outputs(), 64'd0);
    repeat (2) begin
      hc_in      = 10'($urandom_range(0, 639));
      vc_in      = 10'($urandom_range(0, 479));
      frame_done = 1'b1;
      @(negedge clk);
      check_eq("reset_hold", all_outputs(), 64'd0);
    end
    frame_done = 1'b0;
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < N_TILES; a++)
        mem[b][a] = 8'($urandom);
    mem[0][82] = 8'b101_110_01;
    mem[1][82] = 8'b010_001_10;
    rd_data    = 8'd0;
    rst        = 1'b0;
    hc_in      = 10'd0;
    vc_in      = 10'd0;
    frame_done = 1'b0;
    model_reset();

    // Reset held while counters run, then first active pixel.
    @(negedge clk);
    do_reset(0);
    step(0, 0, 0);
    step(1, 0, 0);
    step(2, 0, 0);
    step(3, 0, 0);
    check_eq("first_pix_valid", pix_valid, 1'b1);

    // Address map and data path.
    step(17, 9, 0);
    check_eq("addr_17_9", rd_addr, 13'd82);
    step(640, 9, 0);
    check_eq("addr_hold", rd_addr, 13'd82);
    step(700, 9, 0);
    step(800, 9, 0);
    check_eq("pix_82", {pix_red, pix_green, pix_blue}, {3'd5, 3'd6, 2'd1});
    step(639, 479, 0);
    check_eq("addr_last", rd_addr, 13'd4799);
    step(1023, 1023, 0);
    step(639, 480, 0);
    step(0, 479, 0);

    // Single swap.
    do_reset(0);
    step(10, 100, 1);
    for (int i = 0; i < 6; i++) step($urandom_range(0, 639), $urandom_range(100, 479), 0);
    check_eq("no_early_swap", rd_bank, 1'b0);
    step(0, 480, 0);
    check_eq("swap_bank", rd_bank, 1'b1);
    check_eq("swap_ack_hi", swap_ack, 1'b1);
    step(1, 480, 0);
    check_eq("swap_ack_lo", swap_ack, 1'b0);
    step(17, 9, 0);
    step(640, 9, 0);
    step(640, 9, 0);
    step(640, 9, 0);

    // Overrun: two frame_done pulses before the vblank start.
    do_reset(0);
    step(5, 100, 1);
    step(5, 101, 0);
    step(6, 200, 1);
    check_eq("overrun_set", overrun, 1'b1);
    step(0, 480, 0);
    step(0, 0, 0);
    step(0, 480, 0);
    check_eq("one_swap_only", rd_bank, 1'b1);

    // frame_done on the swap cycle re-arms without overrun.
    do_reset(0);
    step(3, 50, 1);
    step(0, 480, 1);
    step(10, 10, 0);
    step(0, 480, 0);
    check_eq("second_swap", rd_bank, 1'b0);
    check_eq("no_overrun", overrun, 1'b0);

    // Frame counter wrap.
    do_reset(0);
    for (int i = 0; i < 257; i++) step(0, 480, 0);
    check_eq("frame_wrap", frame_cnt, 8'd1);

    // Randomised traffic, split by an asynchronous reset mid-line with a swap pending.
    do_reset(0);
    for (int phase = 0; phase < 2; phase++) begin
      for (int i = 0; i < 1500; i++) begin
        int r;
        r = $urandom_range(0, 99);
        if (r < 3)       step(0, 480, ($urandom_range(0, 3) == 0));
        else if (r < 8)  step($urandom_range(0, 1023), $urandom_range(0, 1023), ($urandom_range(0, 29) == 0));
        else             step($urandom_range(0, 799), $urandom_range(0, 524), ($urandom_range(0, 49) == 0));
      end
      step(100, 100, 1);
      step(300, 200, 0);
      do_reset(7);
      step(0, 480, 0);
      check_eq("dropped_swap_ack", swap_ack, 1'b0);
      check_eq("dropped_swap_bank", rd_bank, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
